// File: rtl/frame_rd_sched_if.sv
// Handshake and status bundle between the frame-read scheduler and its neighbours
// (capture writer, display timing, DDR burst-read engine).
interface frame_rd_sched_if #(
  parameter int unsigned ADDR_BITS = 23
) ();
  logic                 frame_start;
  logic                 wr_frame_done;
  logic [1:0]           wr_frame_idx;
  logic                 read_req;
  logic                 read_req_ack;
  logic                 read_finish;
  logic [ADDR_BITS-1:0] read_addr;
  logic [ADDR_BITS-1:0] read_len;
  logic [1:0]           rd_frame_idx;
  logic                 rd_active;
  logic [7:0]           late_cnt;
  logic                 err_timeout;

  // Scheduler side: issues the read request and reports status.
  modport master (
    input  frame_start, wr_frame_done, wr_frame_idx, read_req_ack, read_finish,
    output read_req, read_addr, read_len, rd_frame_idx, rd_active, late_cnt, err_timeout
  );

  // Environment side: writer, display timing and burst-read engine.
  modport slave (
    output frame_start, wr_frame_done, wr_frame_idx, read_req_ack, read_finish,
    input  read_req, read_addr, read_len, rd_frame_idx, rd_active, late_cnt, err_timeout
  );
endinterface

// File: rtl/frame_rd_sched.sv
// Frame-read scheduler: on each display frame start, requests a burst read of the
// newest completed frame buffer over a 4-phase handshake and tracks its completion.
module frame_rd_sched #(
  parameter int unsigned          ADDR_BITS    = 23,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR    = '0,
  parameter logic [ADDR_BITS-1:0] FRAME_STRIDE = 23'h080000,
  parameter logic [ADDR_BITS-1:0] FRAME_LEN    = 23'h04B000,
  parameter int unsigned          NUM_BUF      = 3,
  parameter int unsigned          ACK_TIMEOUT  = 1023
) (
  input  logic             mem_clk,
  input  logic             rst,
  frame_rd_sched_if.master sched
);

  localparam int unsigned TO_W      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [2:0]  NUM_BUF_W = 3'(NUM_BUF);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_ACKLOW = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  logic [1:0]           r_state,  w_state_nxt;
  logic                 r_have;
  logic [1:0]           r_latest;
  logic                 r_req,    w_req_nxt;
  logic                 r_active, w_active_nxt;
  logic [ADDR_BITS-1:0] r_addr,   w_addr_nxt;
  logic [1:0]           r_idx,    w_idx_nxt;
  logic [7:0]           r_late,   w_late_nxt;
  logic [TO_W-1:0]      r_to_cnt, w_to_nxt;
  logic                 r_err,    w_err_nxt;

  logic                 w_wr_ok;
  logic                 w_have;
  logic [1:0]           w_sel_idx;
  logic [ADDR_BITS-1:0] w_sel_addr;
  logic                 w_late_inc;
  logic                 w_issue;

  // A frame completed this cycle is visible to a same-cycle frame_start (bypass).
  assign w_wr_ok    = sched.wr_frame_done && ({1'b0, sched.wr_frame_idx} < NUM_BUF_W);
  assign w_have     = r_have | w_wr_ok;
  assign w_sel_idx  = w_wr_ok ? sched.wr_frame_idx : r_latest;
  assign w_sel_addr = BASE_ADDR + ADDR_BITS'(w_sel_idx) * FRAME_STRIDE;

  // A finish coinciding with a restart is absorbed by the restart, so it is not late.
  assign w_late_inc = sched.frame_start && r_active &&
                      !((r_state == S_RUN) && sched.read_finish);

  always_comb begin
    w_state_nxt  = r_state;
    w_req_nxt    = r_req;
    w_active_nxt = r_active;
    w_addr_nxt   = r_addr;
    w_idx_nxt    = r_idx;
    w_late_nxt   = r_late;
    w_to_nxt     = r_to_cnt;
    w_err_nxt    = r_err;
    w_issue      = 1'b0;

    if (w_late_inc && (r_late != 8'hFF)) begin
      w_late_nxt = r_late + 8'd1;
    end

    case (r_state)
      S_IDLE: begin
        if (sched.frame_start && w_have) begin
          w_issue = 1'b1;
        end
      end
      S_REQ: begin
        if (sched.read_req_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_ACKLOW;
        end else if (r_to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
          w_req_nxt    = 1'b0;
          w_active_nxt = 1'b0;
          w_err_nxt    = 1'b1;
          w_state_nxt  = S_IDLE;
        end else begin
          w_to_nxt = r_to_cnt + TO_W'(1);
        end
      end
      S_ACKLOW: begin
        if (!sched.read_req_ack) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (sched.frame_start) begin
          w_issue = 1'b1;
        end else if (sched.read_finish) begin
          w_active_nxt = 1'b0;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_issue) begin
      w_state_nxt  = S_REQ;
      w_req_nxt    = 1'b1;
      w_active_nxt = 1'b1;
      w_addr_nxt   = w_sel_addr;
      w_idx_nxt    = w_sel_idx;
      w_to_nxt     = '0;
    end
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_have   <= 1'b0;
      r_latest <= 2'd0;
      r_req    <= 1'b0;
      r_active <= 1'b0;
      r_addr   <= BASE_ADDR;
      r_idx    <= 2'd0;
      r_late   <= 8'd0;
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_have   <= w_have;
      r_latest <= w_sel_idx;
      r_req    <= w_req_nxt;
      r_active <= w_active_nxt;
      r_addr   <= w_addr_nxt;
      r_idx    <= w_idx_nxt;
      r_late   <= w_late_nxt;
      r_to_cnt <= w_to_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign sched.read_req     = r_req;
  assign sched.read_addr    = r_addr;
  assign sched.read_len     = FRAME_LEN;
  assign sched.rd_frame_idx = r_idx;
  assign sched.rd_active    = r_active;
  assign sched.late_cnt     = r_late;
  assign sched.err_timeout  = r_err;

endmodule

// File: tb/tb_frame_rd_sched.sv
// Directed bench for frame_rd_sched: issued requests are queued as expectations and
// checked by a monitor on each read_req rising edge; status outputs are checked inline.
module tb_frame_rd_sched;

  localparam int unsigned AB = 23;

  typedef struct {
    logic [AB-1:0] addr;
    logic [1:0]    idx;
  } exp_t;

  logic   mem_clk = 1'b0;
  logic   rst     = 1'b1;
  exp_t   exp_q[$];
  int     n_vec   = 0;
  int     n_err   = 0;
  logic   mon_prev_req = 1'b0;

  always #5 mem_clk = ~mem_clk;

  frame_rd_sched_if #(.ADDR_BITS(AB)) if0 ();
  frame_rd_sched_if #(.ADDR_BITS(AB)) if1 ();

  frame_rd_sched #(
    .ADDR_BITS(AB), .BASE_ADDR(23'h000000), .FRAME_STRIDE(23'h080000),
    .FRAME_LEN(23'h04B000), .NUM_BUF(3), .ACK_TIMEOUT(15)
  ) u_dut0 (.mem_clk(mem_clk), .rst(rst), .sched(if0));

  frame_rd_sched #(
    .ADDR_BITS(AB), .BASE_ADDR(23'h7C0000), .FRAME_STRIDE(23'h080000),
    .FRAME_LEN(23'h04B000), .NUM_BUF(3), .ACK_TIMEOUT(15)
  ) u_dut1 (.mem_clk(mem_clk), .rst(rst), .sched(if1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic expect_req(input logic [AB-1:0] addr, input logic [1:0] idx);
    exp_t e;
    e.addr = addr;
    e.idx  = idx;
    exp_q.push_back(e);
  endtask

  // Ack rises for hold cycles then falls; scheduler ends in its run state.
  task automatic handshake(input int hold);
    if0.read_req_ack = 1'b1;
    cyc();
    chk("req_drop_after_ack", 32'(if0.read_req), 32'd0);
    repeat (hold - 1) cyc();
    if0.read_req_ack = 1'b0;
    cyc();
  endtask

  task automatic chk_reset0();
    chk("rst_read_req",  32'(if0.read_req),     32'd0);
    chk("rst_read_addr", 32'(if0.read_addr),    32'h000000);
    chk("rst_read_len",  32'(if0.read_len),     32'h04B000);
    chk("rst_idx",       32'(if0.rd_frame_idx), 32'd0);
    chk("rst_active",    32'(if0.rd_active),    32'd0);
    chk("rst_late",      32'(if0.late_cnt),     32'd0);
    chk("rst_err",       32'(if0.err_timeout),  32'd0);
  endtask

  // Scoreboard monitor: every new request must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge mem_clk);
      #2;
      if (if0.read_req && !mon_prev_req) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_req: got request addr 0x%0h idx %0d, expected none",
                   if0.read_addr, if0.rd_frame_idx);
        end else begin
          e = exp_q.pop_front();
          chk("mon_read_addr", 32'(if0.read_addr),    32'(e.addr));
          chk("mon_rd_idx",    32'(if0.rd_frame_idx), 32'(e.idx));
        end
      end
      mon_prev_req = if0.read_req;
    end
  end

  initial begin
    int n;
    if0.frame_start = 1'b0; if0.wr_frame_done = 1'b0; if0.wr_frame_idx = 2'd0;
    if0.read_req_ack = 1'b0; if0.read_finish = 1'b0;
    if1.frame_start = 1'b0; if1.wr_frame_done = 1'b0; if1.wr_frame_idx = 2'd0;
    if1.read_req_ack = 1'b0; if1.read_finish = 1'b0;

    repeat (3) cyc();
    chk_reset0();
    rst = 1'b0;
    cyc();

    // frame_start with no completed frame: nothing happens
    if0.frame_start = 1'b1; cyc(); if0.frame_start = 1'b0;
    cyc();
    chk("nofrm_req",    32'(if0.read_req),  32'd0);
    chk("nofrm_active", 32'(if0.rd_active), 32'd0);
    chk("nofrm_late",   32'(if0.late_cnt),  32'd0);

    // idx 2 completed, then frame_start; ack held 5 cycles
    if0.wr_frame_done = 1'b1; if0.wr_frame_idx = 2'd2; cyc(); if0.wr_frame_done = 1'b0;
    if0.frame_start = 1'b1; expect_req(23'h100000, 2'd2); cyc(); if0.frame_start = 1'b0;
    chk("issue_latency", 32'(if0.read_req),  32'd1);
    chk("issue_active",  32'(if0.rd_active), 32'd1);
    handshake(5);
    if0.read_finish = 1'b1; cyc(); if0.read_finish = 1'b0;
    chk("finish_active", 32'(if0.rd_active),    32'd0);
    chk("finish_idx",    32'(if0.rd_frame_idx), 32'd2);

    // same-cycle wr_frame_done idx 1 and frame_start
    if0.wr_frame_done = 1'b1; if0.wr_frame_idx = 2'd1; if0.frame_start = 1'b1;
    expect_req(23'h080000, 2'd1);
    cyc();
    if0.wr_frame_done = 1'b0; if0.frame_start = 1'b0;
    chk("bypass_req", 32'(if0.read_req), 32'd1);
    handshake(1);

    // restart in S_RUN with idx 0
    if0.wr_frame_done = 1'b1; if0.wr_frame_idx = 2'd0; cyc(); if0.wr_frame_done = 1'b0;
    if0.frame_start = 1'b1; expect_req(23'h000000, 2'd0); cyc(); if0.frame_start = 1'b0;
    chk("restart_late", 32'(if0.late_cnt), 32'd1);
    chk("restart_req",  32'(if0.read_req), 32'd1);
    // stale finish in S_REQ ignored; frame_start in S_REQ only counted
    if0.read_finish = 1'b1; cyc(); if0.read_finish = 1'b0;
    chk("stale_finish_active", 32'(if0.rd_active), 32'd1);
    chk("stale_finish_req",    32'(if0.read_req),  32'd1);
    if0.frame_start = 1'b1; cyc(); if0.frame_start = 1'b0;
    chk("req_late_counted", 32'(if0.late_cnt), 32'd2);
    handshake(1);

    // out-of-range index ignored; finish+frame_start together restarts, not late
    if0.wr_frame_done = 1'b1; if0.wr_frame_idx = 2'd3; cyc(); if0.wr_frame_done = 1'b0;
    if0.read_finish = 1'b1; if0.frame_start = 1'b1; expect_req(23'h000000, 2'd0);
    cyc();
    if0.read_finish = 1'b0; if0.frame_start = 1'b0;
    chk("fin_restart_active", 32'(if0.rd_active),    32'd1);
    chk("fin_restart_late",   32'(if0.late_cnt),     32'd2);
    chk("fin_restart_req",    32'(if0.read_req),     32'd1);
    chk("bad_idx_ignored",    32'(if0.rd_frame_idx), 32'd0);
    handshake(1);
    if0.read_finish = 1'b1; cyc(); if0.read_finish = 1'b0;
    chk("finish2_active", 32'(if0.rd_active), 32'd0);

    // ack never returned: request held exactly ACK_TIMEOUT cycles
    if0.frame_start = 1'b1; expect_req(23'h000000, 2'd0); cyc(); if0.frame_start = 1'b0;
    n = if0.read_req ? 1 : 0;
    repeat (20) begin
      cyc();
      if (if0.read_req) n++;
    end
    chk("timeout_req_cycles", 32'(n),               32'd15);
    chk("timeout_err",        32'(if0.err_timeout), 32'd1);
    chk("timeout_active",     32'(if0.rd_active),   32'd0);
    if0.frame_start = 1'b1; expect_req(23'h000000, 2'd0); cyc(); if0.frame_start = 1'b0;
    chk("after_timeout_req", 32'(if0.read_req),    32'd1);
    handshake(2);
    if0.read_finish = 1'b1; cyc(); if0.read_finish = 1'b0;
    chk("err_sticky", 32'(if0.err_timeout), 32'd1);

    // late_cnt saturates while ack is held high in S_ACKLOW
    if0.frame_start = 1'b1; expect_req(23'h000000, 2'd0); cyc(); if0.frame_start = 1'b0;
    if0.read_req_ack = 1'b1; cyc();
    if0.frame_start = 1'b1;
    repeat (260) cyc();
    if0.frame_start = 1'b0;
    chk("late_saturate",   32'(if0.late_cnt), 32'd255);
    chk("acklow_hold_req", 32'(if0.read_req), 32'd0);
    if0.read_req_ack = 1'b0; cyc();

    // reset while running
    rst = 1'b1; cyc();
    chk_reset0();
    chk("rst_addr_dut1", 32'(if1.read_addr), 32'h7C0000);
    rst = 1'b0; cyc();

    // address wraps modulo 2^23
    if1.wr_frame_done = 1'b1; if1.wr_frame_idx = 2'd2; cyc(); if1.wr_frame_done = 1'b0;
    if1.frame_start = 1'b1; cyc(); if1.frame_start = 1'b0;
    chk("wrap_req",  32'(if1.read_req),     32'd1);
    chk("wrap_addr", 32'(if1.read_addr),    32'h0C0000);
    chk("wrap_idx",  32'(if1.rd_frame_idx), 32'd2);

    repeat (3) cyc();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_rd_sched.md
Name: frame_rd_sched

Overview:
- Frame-read scheduler that sits directly upstream of the DDR burst-read engine (fifo_read) in the mem_clk domain.
- On each display frame start, it picks the most recently completed frame buffer written by the capture path.
- It issues the read request with address and length, holds it under a 4-phase handshake, and tracks completion or restart.
- It exports the buffer index in use so the writer can avoid it.

Parameters:
ADDR_BITS, 23, width of read_addr and read_len
BASE_ADDR, 0, address of frame buffer 0
FRAME_STRIDE, 23'h080000, address distance between consecutive buffers
FRAME_LEN, 23'h04B000, value driven on read_len; same units as the burst engine's read counter
NUM_BUF, 3, number of frame buffers (2..4)
ACK_TIMEOUT, 1023, maximum cycles read_req stays high without read_req_ack

Ports:
mem_clk  input  1  clock; all logic on rising edge
rst  input  1  reset; synchronous, active-high
frame_start  input  1  one-cycle pulse, display frame start, already synchronous to mem_clk
wr_frame_done  input  1  one-cycle pulse, writer completed a frame
wr_frame_idx  input  2  buffer index completed, valid with wr_frame_done
read_req  output  1  request to burst-read engine; held until read_req_ack=1
read_req_ack  input  1  acknowledge from burst-read engine
read_finish  input  1  one-cycle pulse, frame read complete
read_addr  output  ADDR_BITS  base address of requested frame
read_len  output  ADDR_BITS  frame length (constant FRAME_LEN)
rd_frame_idx  output  2  buffer currently being read
rd_active  output  1  high from request issue until read_finish/abort
late_cnt  output  8  saturating count of frame_start arriving while rd_active
err_timeout  output  1  sticky; set on handshake timeout, cleared by rst

Behaviour:
- Reset values: read_req=0; read_addr=BASE_ADDR; read_len=FRAME_LEN; rd_frame_idx=0; rd_active=0; late_cnt=0; err_timeout=0. Internally, have_frame=0, latest_idx=0, and FSM=S_IDLE.
- Reset mid-operation drops read_req the next cycle; no handshake completion is attempted.
- Frame tracking: wr_frame_done with wr_frame_idx<NUM_BUF sets latest_idx=wr_frame_idx and have_frame=1. Indexes >=NUM_BUF are ignored.
- Address calculation: read_addr = BASE_ADDR + idx*FRAME_STRIDE, truncated to ADDR_BITS (wraps mod 2^ADDR_BITS). It is registered in the cycle the request is issued and held stable while read_req=1.
- FSM states:
  - S_IDLE: on frame_start with have_frame=1, latch idx=latest_idx, drive rd_frame_idx and read_addr, set read_req=1 and rd_active=1, go to S_REQ. On frame_start with have_frame=0, remain in S_IDLE and assert no request.
  - S_REQ: hold read_req=1 and count timeout. On read_req_ack=1, clear read_req next cycle and go to S_ACKLOW. If the counter reaches ACK_TIMEOUT without ack, clear read_req and rd_active, set err_timeout, and go to S_IDLE.
  - S_ACKLOW: wait for read_req_ack=0, then go to S_RUN. Ack staying high for any length is legal.
  - S_RUN: on read_finish, clear rd_active and go to S_IDLE.
- frame_start while rd_active=1 (S_REQ/S_ACKLOW/S_RUN): late_cnt++ (saturates at 255).
  - In S_RUN it restarts: latch the new latest_idx and recompute read_addr, set read_req=1, go to S_REQ. The downstream engine re-enters its ACK state on a new request, so no abort signal is needed.
  - In S_REQ/S_ACKLOW it is counted only; the handshake completes unchanged.
- Simultaneous wr_frame_done and frame_start in the same cycle: the new wr_frame_idx is used (bypass).
- read_finish outside S_RUN is ignored. read_finish and frame_start together in S_RUN: the restart takes priority; rd_active stays 1 and late_cnt is not incremented.
- Latency: frame_start to read_req=1 is 1 cycle. read_req_ack=1 to read_req=0 is 1 cycle.
- rd_frame_idx holds its value after completion until the next request.

Test Plan:
- Reset, then frame_start with no wr_frame_done → read_req stays 0, rd_active=0, late_cnt=0.
- wr_frame_done idx=2, then frame_start (BASE_ADDR=0, FRAME_STRIDE=0x80000) → next cycle read_req=1, read_addr=0x100000, rd_frame_idx=2. Ack held 5 cycles → read_req=0 one cycle after ack rises. read_finish → rd_active=0.
- wr_frame_done idx=1 and frame_start in the same cycle → read_addr=0x080000, rd_frame_idx=1.
- In S_RUN, wr_frame_done idx=0 then frame_start → late_cnt=1, read_req reasserts with read_addr=0, state S_REQ. A late read_finish for the old request while in S_REQ is ignored.
- Ack never returned (ACK_TIMEOUT=15) → read_req falls after 15 cycles, err_timeout=1, rd_active=0. Next frame_start issues a fresh request; err_timeout stays 1 until rst.
- Assert rst while in S_RUN → next cycle all outputs at reset values. BASE_ADDR=0x7C0000 with idx=2 → read_addr wraps to 0x0C0000.
